rom_port_server: RTL and testbench

SDRAM-side responder for the core's four ROM fetch ports: 68k program, tile graphics, sprite graphics, theme samples. Each port sends a one-cycle request pulse with an address. This block latches the pulse, arbitrates, and runs one transaction at a time on the SDRAM controller's req/ack port. It returns the fetched data on that port's data bus and drives the 68k wait line `sdram_dtack`. It sits in the top-level between the game core and the SDRAM controller.

---
 rtl/rom_port_pkg.sv | 22 ++
 rtl/rom_port_slot.sv | 68 ++++++
 rtl/rom_port_server.sv | 163 ++++++++++++++++
 tb/tb_rom_port_server.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_port_pkg.sv
// rtl/rom_port_pkg.sv - shared types and default ROM bases for rom_port_server
package rom_port_pkg;

  // Port order doubles as arbitration priority: lowest index wins
  typedef enum logic [1:0] {
    P_TILES = 2'd0,
    P_SPR   = 2'd1,
    P_M68K  = 2'd2,
    P_THEME = 2'd3
  } port_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  localparam logic [24:0] DEF_M68K_BASE  = 25'h0000000;
  localparam logic [24:0] DEF_TILES_BASE = 25'h0100000;
  localparam logic [24:0] DEF_SPR_BASE   = 25'h0200000;
  localparam logic [24:0] DEF_THEME_BASE = 25'h0400000;

endpackage

// File: rtl/rom_port_slot.sv
// rtl/rom_port_slot.sv - one fetch port: pending flag, address latch, data register
module rom_port_slot #(
  parameter int AW = 18,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  input  logic          i_grant,
  input  logic          i_done,
  input  logic [DW-1:0] i_data,
  output logic          o_pending,
  output logic          o_fresh,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data
);

  logic          r_pending;
  logic          r_fresh;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  // Pending/fresh tracking: flush dominates, a new request beats completion.
  // r_fresh marks a request newer than the one in flight, so completion
  // of the older fetch must not retire it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_fresh   <= 1'b0;
    end else if (i_flush) begin
      r_pending <= 1'b0;
      r_fresh   <= 1'b0;
    end else begin
      if (i_req)
        r_pending <= 1'b1;
      else if (i_done && !r_fresh)
        r_pending <= 1'b0;
      if (i_req)
        r_fresh <= 1'b1;
      else if (i_grant)
        r_fresh <= 1'b0;
    end
  end

  // Address latch: the most recent request always wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_addr <= '0;
    else if (i_req)
      r_addr <= i_addr;
  end

  // Data register: updated only on this port's completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_data <= '0;
    else if (i_done)
      r_data <= i_data;
  end

  assign o_pending = r_pending;
  assign o_fresh   = r_fresh;
  assign o_addr    = r_addr;
  assign o_data    = r_data;

endmodule

// File: rtl/rom_port_server.sv
// rtl/rom_port_server.sv - arbitrates four ROM fetch ports onto one SDRAM req/ack channel
module rom_port_server
  import rom_port_pkg::*;
#(
  parameter logic [24:0] M68K_BASE  = DEF_M68K_BASE,
  parameter logic [24:0] TILES_BASE = DEF_TILES_BASE,
  parameter logic [24:0] SPR_BASE   = DEF_SPR_BASE,
  parameter logic [24:0] THEME_BASE = DEF_THEME_BASE
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        load_en,
  input  logic        m68k_rom_req,
  input  logic [17:0] m68k_rom_addr,
  output logic [15:0] m68k_rom_dout,
  output logic        sdram_dtack,
  input  logic        tiles_rom_req,
  input  logic [17:0] tiles_rom_addr,
  output logic [31:0] tiles_rom_dout,
  input  logic        spr_rom_req,
  input  logic [18:0] spr_rom_addr,
  output logic [31:0] spr_rom_dout,
  input  logic        theme_rom_req,
  input  logic [17:0] theme_rom_addr,
  output logic [31:0] theme_rom_dout,
  output logic        sd_req,
  output logic [24:0] sd_addr,
  input  logic        sd_ack,
  input  logic [31:0] sd_dout
);

  state_e      r_state;
  state_e      w_state_nxt;
  port_e       r_grant;
  port_e       w_sel;
  logic [3:0]  w_pend;
  logic [3:0]  w_fresh;
  logic        w_any;
  logic        w_grant_go;
  logic        w_done;
  logic        w_sd_req;
  logic [24:0] r_sd_addr;
  logic [24:0] w_addr_nxt;
  logic        r_m68k_half;
  logic        r_dtack;
  logic [17:0] w_m68k_addr;
  logic [17:0] w_tiles_addr;
  logic [18:0] w_spr_addr;
  logic [17:0] w_theme_addr;
  logic [15:0] w_m68k_word;

  assign w_any       = |w_pend;
  assign w_m68k_word = r_m68k_half ? sd_dout[31:16] : sd_dout[15:0];

  rom_port_slot #(.AW(18), .DW(32)) u_tiles (
    .clk(clk_sys), .rst(reset), .i_req(tiles_rom_req), .i_addr(tiles_rom_addr),
    .i_flush(load_en), .i_grant(w_grant_go && (w_sel == P_TILES)),
    .i_done(w_done && (r_grant == P_TILES)), .i_data(sd_dout),
    .o_pending(w_pend[P_TILES]), .o_fresh(w_fresh[P_TILES]),
    .o_addr(w_tiles_addr), .o_data(tiles_rom_dout)
  );

  rom_port_slot #(.AW(19), .DW(32)) u_spr (
    .clk(clk_sys), .rst(reset), .i_req(spr_rom_req), .i_addr(spr_rom_addr),
    .i_flush(load_en), .i_grant(w_grant_go && (w_sel == P_SPR)),
    .i_done(w_done && (r_grant == P_SPR)), .i_data(sd_dout),
    .o_pending(w_pend[P_SPR]), .o_fresh(w_fresh[P_SPR]),
    .o_addr(w_spr_addr), .o_data(spr_rom_dout)
  );

  rom_port_slot #(.AW(18), .DW(16)) u_m68k (
    .clk(clk_sys), .rst(reset), .i_req(m68k_rom_req), .i_addr(m68k_rom_addr),
    .i_flush(load_en), .i_grant(w_grant_go && (w_sel == P_M68K)),
    .i_done(w_done && (r_grant == P_M68K)), .i_data(w_m68k_word),
    .o_pending(w_pend[P_M68K]), .o_fresh(w_fresh[P_M68K]),
    .o_addr(w_m68k_addr), .o_data(m68k_rom_dout)
  );

  rom_port_slot #(.AW(18), .DW(32)) u_theme (
    .clk(clk_sys), .rst(reset), .i_req(theme_rom_req), .i_addr(theme_rom_addr),
    .i_flush(load_en), .i_grant(w_grant_go && (w_sel == P_THEME)),
    .i_done(w_done && (r_grant == P_THEME)), .i_data(sd_dout),
    .o_pending(w_pend[P_THEME]), .o_fresh(w_fresh[P_THEME]),
    .o_addr(w_theme_addr), .o_data(theme_rom_dout)
  );

  // Fixed-priority pick: tiles > sprites > m68k > theme
  always_comb begin
    w_sel = P_THEME;
    if (w_pend[P_TILES])
      w_sel = P_TILES;
    else if (w_pend[P_SPR])
      w_sel = P_SPR;
    else if (w_pend[P_M68K])
      w_sel = P_M68K;
  end

  // Byte address of the selected port; m68k drops the half-word bit
  always_comb begin
    w_addr_nxt = THEME_BASE + {5'd0, w_theme_addr, 2'b00};
    case (w_sel)
      P_TILES: w_addr_nxt = TILES_BASE + {5'd0, w_tiles_addr, 2'b00};
      P_SPR:   w_addr_nxt = SPR_BASE + {4'd0, w_spr_addr, 2'b00};
      P_M68K:  w_addr_nxt = M68K_BASE + {6'd0, w_m68k_addr[17:1], 2'b00};
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // FSM next state: issue from IDLE, return on ack
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!load_en && w_any) w_state_nxt = S_BUSY;
      S_BUSY:  if (sd_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: request level, grant and completion strobes
  always_comb begin
    w_sd_req   = (r_state == S_BUSY);
    w_grant_go = (r_state == S_IDLE) && !load_en && w_any;
    w_done     = (r_state == S_BUSY) && sd_ack;
  end

  // Transaction registers captured at grant and held through BUSY
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_grant     <= P_TILES;
      r_sd_addr   <= '0;
      r_m68k_half <= 1'b0;
    end else if (w_grant_go) begin
      r_grant     <= w_sel;
      r_sd_addr   <= w_addr_nxt;
      r_m68k_half <= w_m68k_addr[0];
    end
  end

  // 68k wait line: drops on request, rises once the newest m68k fetch lands
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      r_dtack <= 1'b1;
    else if (load_en)
      r_dtack <= 1'b1;
    else if (m68k_rom_req)
      r_dtack <= 1'b0;
    else if (w_done && (r_grant == P_M68K) && !w_fresh[r_grant])
      r_dtack <= 1'b1;
  end

  assign sd_req      = w_sd_req;
  assign sd_addr     = r_sd_addr;
  assign sdram_dtack = r_dtack;

endmodule

// File: tb/tb_rom_port_server.sv
// tb/tb_rom_port_server.sv - self-checking bench for rom_port_server
`timescale 1ns/1ps
module tb_rom_port_server;

  localparam logic [24:0] TB_M68K  = 25'h0000000;
  localparam logic [24:0] TB_TILES = 25'h0100000;
  localparam logic [24:0] TB_SPR   = 25'h0200000;
  localparam logic [24:0] TB_THEME = 25'h0400000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        load_en;
  logic        m68k_rom_req;
  logic [17:0] m68k_rom_addr;
  logic [15:0] m68k_rom_dout;
  logic        sdram_dtack;
  logic        tiles_rom_req;
  logic [17:0] tiles_rom_addr;
  logic [31:0] tiles_rom_dout;
  logic        spr_rom_req;
  logic [18:0] spr_rom_addr;
  logic [31:0] spr_rom_dout;
  logic        theme_rom_req;
  logic [17:0] theme_rom_addr;
  logic [31:0] theme_rom_dout;
  logic        sd_req;
  logic [24:0] sd_addr;
  logic        sd_ack;
  logic [31:0] sd_dout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_sys = ~clk_sys;

  rom_port_server dut (
    .clk_sys(clk_sys), .reset(reset), .load_en(load_en),
    .m68k_rom_req(m68k_rom_req), .m68k_rom_addr(m68k_rom_addr),
    .m68k_rom_dout(m68k_rom_dout), .sdram_dtack(sdram_dtack),
    .tiles_rom_req(tiles_rom_req), .tiles_rom_addr(tiles_rom_addr),
    .tiles_rom_dout(tiles_rom_dout),
    .spr_rom_req(spr_rom_req), .spr_rom_addr(spr_rom_addr),
    .spr_rom_dout(spr_rom_dout),
    .theme_rom_req(theme_rom_req), .theme_rom_addr(theme_rom_addr),
    .theme_rom_dout(theme_rom_dout),
    .sd_req(sd_req), .sd_addr(sd_addr), .sd_ack(sd_ack), .sd_dout(sd_dout)
  );

  task automatic step();
    @(negedge clk_sys);
  endtask

  task automatic idle_inputs();
    load_en = 1'b0; sd_ack = 1'b0;
    m68k_rom_req = 1'b0; tiles_rom_req = 1'b0; spr_rom_req = 1'b0; theme_rom_req = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (sd_req === 1'b1) ok = 1'b1;
      else step();
    end
  endtask

  task automatic ack_after(input int lat, input logic [31:0] d);
    repeat (lat - 1) step();
    sd_ack = 1'b1; sd_dout = d;
    step();
    sd_ack = 1'b0;
  endtask

  function automatic int prio(input bit [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic logic [24:0] form(input int p, input logic [18:0] a);
    case (p)
      0:       return TB_TILES + 25'(a[17:0]) * 25'd4;
      1:       return TB_SPR + 25'(a) * 25'd4;
      2:       return TB_M68K + 25'(a[17:1]) * 25'd4;
      default: return TB_THEME + 25'(a[17:0]) * 25'd4;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; idle_inputs(); sd_dout = '0;
    m68k_rom_addr = '0; tiles_rom_addr = '0; spr_rom_addr = '0; theme_rom_addr = '0;
    step(); step();
    vectors++; if (sd_req !== 1'b0) begin miscompares++; $display("FAIL reset_sd_req: got %b want 0", sd_req); end
    vectors++; if (sd_addr !== 25'h0) begin miscompares++; $display("FAIL reset_sd_addr: got %h want 0", sd_addr); end
    vectors++; if (sdram_dtack !== 1'b1) begin miscompares++; $display("FAIL reset_dtack: got %b want 1", sdram_dtack); end
    vectors++; if (m68k_rom_dout !== 16'h0) begin miscompares++; $display("FAIL reset_m68k_dout: got %h want 0", m68k_rom_dout); end
    vectors++; if (tiles_rom_dout !== 32'h0) begin miscompares++; $display("FAIL reset_tiles_dout: got %h want 0", tiles_rom_dout); end
    vectors++; if (spr_rom_dout !== 32'h0) begin miscompares++; $display("FAIL reset_spr_dout: got %h want 0", spr_rom_dout); end
    vectors++; if (theme_rom_dout !== 32'h0) begin miscompares++; $display("FAIL reset_theme_dout: got %h want 0", theme_rom_dout); end
    reset = 1'b0;
    step();
    vectors++; if (sd_req !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: got %b want 0", sd_req); end
  endtask

  task automatic test_single_m68k();
    m68k_rom_req = 1'b1; m68k_rom_addr = 18'h00003;
    step();
    m68k_rom_req = 1'b0;
    vectors++; if (sdram_dtack !== 1'b0) begin miscompares++; $display("FAIL m68k_dtack_low: got %b want 0", sdram_dtack); end
    vectors++; if (sd_req !== 1'b0) begin miscompares++; $display("FAIL m68k_req_early: got %b want 0", sd_req); end
    step();
    vectors++; if (sd_req !== 1'b1) begin miscompares++; $display("FAIL m68k_req_issue: got %b want 1", sd_req); end
    vectors++; if (sd_addr !== 25'h0000004) begin miscompares++; $display("FAIL m68k_sd_addr: got %h want 0000004", sd_addr); end
    repeat (4) step();
    vectors++; if (sdram_dtack !== 1'b0) begin miscompares++; $display("FAIL m68k_dtack_hold: got %b want 0", sdram_dtack); end
    sd_ack = 1'b1; sd_dout = 32'hAABBCCDD;
    step();
    sd_ack = 1'b0;
    vectors++; if (sd_req !== 1'b0) begin miscompares++; $display("FAIL m68k_req_drop: got %b want 0", sd_req); end
    vectors++; if (m68k_rom_dout !== 16'hAABB) begin miscompares++; $display("FAIL m68k_dout: got %h want AABB", m68k_rom_dout); end
    vectors++; if (sdram_dtack !== 1'b1) begin miscompares++; $display("FAIL m68k_dtack_high: got %b want 1", sdram_dtack); end
  endtask

  task automatic test_priority();
    bit ok;
    tiles_rom_req = 1'b1; tiles_rom_addr = 18'h00010;
    m68k_rom_req = 1'b1; m68k_rom_addr = 18'h00101;
    theme_rom_req = 1'b1; theme_rom_addr = 18'h3FFFF;
    step();
    idle_inputs();
    wait_req(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL prio_wait1: got timeout want sd_req"); end
    vectors++; if (sd_addr !== 25'h0100040) begin miscompares++; $display("FAIL prio_tiles_addr: got %h want 0100040", sd_addr); end
    ack_after(3, 32'h11112222);
    vectors++; if (sd_req !== 1'b0) begin miscompares++; $display("FAIL prio_turn1: got %b want 0", sd_req); end
    vectors++; if (tiles_rom_dout !== 32'h11112222) begin miscompares++; $display("FAIL prio_tiles_dout: got %h want 11112222", tiles_rom_dout); end
    wait_req(ok);
    vectors++; if (sd_addr !== 25'h0000200) begin miscompares++; $display("FAIL prio_m68k_addr: got %h want 0000200", sd_addr); end
    ack_after(2, 32'h33334444);
    vectors++; if (sd_req !== 1'b0) begin miscompares++; $display("FAIL prio_turn2: got %b want 0", sd_req); end
    vectors++; if (m68k_rom_dout !== 16'h3333) begin miscompares++; $display("FAIL prio_m68k_dout: got %h want 3333", m68k_rom_dout); end
    vectors++; if (sdram_dtack !== 1'b1) begin miscompares++; $display("FAIL prio_dtack: got %b want 1", sdram_dtack); end
    wait_req(ok);
    vectors++; if (sd_addr !== 25'h04FFFFC) begin miscompares++; $display("FAIL prio_theme_addr: got %h want 04FFFFC", sd_addr); end
    ack_after(4, 32'h55667788);
    vectors++; if (theme_rom_dout !== 32'h55667788) begin miscompares++; $display("FAIL prio_theme_dout: got %h want 55667788", theme_rom_dout); end
  endtask

  task automatic test_overwrite();
    bit ok;
    int extra;
    tiles_rom_req = 1'b1; tiles_rom_addr = 18'h00001;
    step();
    tiles_rom_req = 1'b0;
    wait_req(ok);
    vectors++; if (sd_addr !== 25'h0100004) begin miscompares++; $display("FAIL ovw_tiles_addr: got %h want 0100004", sd_addr); end
    spr_rom_req = 1'b1; spr_rom_addr = 19'd1;
    step();
    spr_rom_addr = 19'd2;
    step();
    spr_rom_req = 1'b0;
    sd_ack = 1'b1; sd_dout = 32'hCAFEF00D;
    step();
    sd_ack = 1'b0;
    wait_req(ok);
    vectors++; if (sd_addr !== 25'h0200008) begin miscompares++; $display("FAIL ovw_spr_addr: got %h want 0200008", sd_addr); end
    ack_after(2, 32'h0BADBEEF);
    vectors++; if (spr_rom_dout !== 32'h0BADBEEF) begin miscompares++; $display("FAIL ovw_spr_dout: got %h want 0BADBEEF", spr_rom_dout); end
    extra = 0;
    for (int i = 0; i < 6; i++) begin if (sd_req === 1'b1) extra++; step(); end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL ovw_single_txn: got %0d extra req cycles want 0", extra); end
  endtask

  task automatic test_rerequest();
    bit ok;
    int extra;
    tiles_rom_req = 1'b1; tiles_rom_addr = 18'd5;
    step();
    tiles_rom_req = 1'b0;
    wait_req(ok);
    vectors++; if (sd_addr !== 25'h0100014) begin miscompares++; $display("FAIL rereq_addr1: got %h want 0100014", sd_addr); end
    step();
    sd_ack = 1'b1; sd_dout = 32'h01020304;
    tiles_rom_req = 1'b1; tiles_rom_addr = 18'd6;
    step();
    sd_ack = 1'b0; tiles_rom_req = 1'b0;
    vectors++; if (tiles_rom_dout !== 32'h01020304) begin miscompares++; $display("FAIL rereq_dout1: got %h want 01020304", tiles_rom_dout); end
    wait_req(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rereq_second: got timeout want sd_req"); end
    vectors++; if (sd_addr !== 25'h0100018) begin miscompares++; $display("FAIL rereq_addr2: got %h want 0100018", sd_addr); end
    ack_after(1, 32'h05060708);
    vectors++; if (tiles_rom_dout !== 32'h05060708) begin miscompares++; $display("FAIL rereq_dout2: got %h want 05060708", tiles_rom_dout); end
    extra = 0;
    for (int i = 0; i < 6; i++) begin if (sd_req === 1'b1) extra++; step(); end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL rereq_no_third: got %0d want 0", extra); end
  endtask

  task automatic test_load_en();
    bit ok;
    int extra;
    tiles_rom_req = 1'b1; tiles_rom_addr = 18'd7;
    step();
    tiles_rom_req = 1'b0;
    wait_req(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL load_issue: got timeout want sd_req"); end
    spr_rom_req = 1'b1; spr_rom_addr = 19'd3;
    m68k_rom_req = 1'b1; m68k_rom_addr = 18'd9;
    theme_rom_req = 1'b1; theme_rom_addr = 18'd4;
    step();
    spr_rom_req = 1'b0; m68k_rom_req = 1'b0; theme_rom_req = 1'b0;
    load_en = 1'b1;
    step();
    vectors++; if (sdram_dtack !== 1'b1) begin miscompares++; $display("FAIL load_dtack_forced: got %b want 1", sdram_dtack); end
    sd_ack = 1'b1; sd_dout = 32'h77778888;
    step();
    sd_ack = 1'b0;
    vectors++; if (tiles_rom_dout !== 32'h77778888) begin miscompares++; $display("FAIL load_inflight_dout: got %h want 77778888", tiles_rom_dout); end
    extra = 0;
    for (int i = 0; i < 8; i++) begin if (sd_req === 1'b1) extra++; step(); end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL load_no_grant: got %0d want 0", extra); end
    load_en = 1'b0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin if (sd_req === 1'b1) extra++; step(); end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL load_pend_cleared: got %0d want 0", extra); end
    vectors++; if (sdram_dtack !== 1'b1) begin miscompares++; $display("FAIL load_dtack_after: got %b want 1", sdram_dtack); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    m68k_rom_req = 1'b1; m68k_rom_addr = 18'h00010;
    step();
    m68k_rom_req = 1'b0;
    wait_req(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_issue: got timeout want sd_req"); end
    reset = 1'b1;
    #1;
    vectors++; if (sd_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_req_async: got %b want 0", sd_req); end
    step();
    reset = 1'b0;
    vectors++; if (tiles_rom_dout !== 32'h0) begin miscompares++; $display("FAIL rstmid_tiles_dout: got %h want 0", tiles_rom_dout); end
    vectors++; if (sdram_dtack !== 1'b1) begin miscompares++; $display("FAIL rstmid_dtack: got %b want 1", sdram_dtack); end
    step(); step();
    sd_ack = 1'b1; sd_dout = 32'hDEADBEEF;
    step();
    sd_ack = 1'b0;
    step();
    vectors++; if (sd_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_late_ack_req: got %b want 0", sd_req); end
    vectors++; if (m68k_rom_dout !== 16'h0) begin miscompares++; $display("FAIL rstmid_late_ack_dout: got %h want 0", m68k_rom_dout); end
    vectors++; if (sd_addr !== 25'h0) begin miscompares++; $display("FAIL rstmid_sd_addr: got %h want 0", sd_addr); end
  endtask

  task automatic test_random();
    bit [3:0]    m_pend;
    logic [18:0] m_addr [4];
    logic [31:0] m_dout [4];
    logic [24:0] m_sd_addr;
    bit          m_busy, m_half, m_dtack, dclr;
    int          m_g, wait_cnt, load_cnt, nxt;
    bit [3:0]    req;
    logic [18:0] a [4];

    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_pend = '0; m_busy = 1'b0; m_half = 1'b0; m_dtack = 1'b1; m_g = 0;
    m_sd_addr = '0; wait_cnt = 0; load_cnt = 0;
    for (int p = 0; p < 4; p++) begin m_addr[p] = '0; m_dout[p] = '0; end

    for (int cyc = 0; cyc < 700; cyc++) begin
      vectors++; if (sd_req !== m_busy) begin miscompares++; $display("FAIL rnd_sd_req @%0d: got %b want %b", cyc, sd_req, m_busy); end
      vectors++; if (sd_addr !== m_sd_addr) begin miscompares++; $display("FAIL rnd_sd_addr @%0d: got %h want %h", cyc, sd_addr, m_sd_addr); end
      vectors++; if (tiles_rom_dout !== m_dout[0]) begin miscompares++; $display("FAIL rnd_tiles_dout @%0d: got %h want %h", cyc, tiles_rom_dout, m_dout[0]); end
      vectors++; if (spr_rom_dout !== m_dout[1]) begin miscompares++; $display("FAIL rnd_spr_dout @%0d: got %h want %h", cyc, spr_rom_dout, m_dout[1]); end
      vectors++; if (m68k_rom_dout !== m_dout[2][15:0]) begin miscompares++; $display("FAIL rnd_m68k_dout @%0d: got %h want %h", cyc, m68k_rom_dout, m_dout[2][15:0]); end
      vectors++; if (theme_rom_dout !== m_dout[3]) begin miscompares++; $display("FAIL rnd_theme_dout @%0d: got %h want %h", cyc, theme_rom_dout, m_dout[3]); end
      vectors++; if (sdram_dtack !== m_dtack) begin miscompares++; $display("FAIL rnd_dtack @%0d: got %b want %b", cyc, sdram_dtack, m_dtack); end

      if (load_cnt > 0) load_cnt--;
      else if ($urandom_range(0, 99) == 0) load_cnt = $urandom_range(1, 6);
      load_en = (load_cnt > 0);

      if (m_busy) begin
        if (wait_cnt <= 1) sd_ack = 1'b1;
        else begin sd_ack = 1'b0; wait_cnt--; end
      end else begin
        sd_ack = ($urandom_range(0, 15) == 0);
      end
      sd_dout = $urandom;

      nxt = (!m_busy && !load_en) ? prio(m_pend) : -1;
      for (int p = 0; p < 4; p++) begin
        req[p] = ($urandom_range(0, 5) == 0);
        if (m_busy && m_g == p && !sd_ack) req[p] = 1'b0;
        if (nxt == p) req[p] = 1'b0;
        a[p] = 19'($urandom);
      end
      tiles_rom_req = req[0]; tiles_rom_addr = a[0][17:0];
      spr_rom_req   = req[1]; spr_rom_addr   = a[1];
      m68k_rom_req  = req[2]; m68k_rom_addr  = a[2][17:0];
      theme_rom_req = req[3]; theme_rom_addr = a[3][17:0];

      dclr = 1'b0;
      if (m_busy && sd_ack) begin
        if (m_g == 2) m_dout[2] = {16'h0, (m_half ? sd_dout[31:16] : sd_dout[15:0])};
        else m_dout[m_g] = sd_dout;
        m_pend[m_g] = 1'b0;
        dclr = (m_g == 2);
        m_busy = 1'b0;
      end else if (!m_busy && !load_en && m_pend != 0) begin
        m_g = prio(m_pend);
        m_sd_addr = form(m_g, m_addr[m_g]);
        m_half = m_addr[m_g][0];
        m_busy = 1'b1;
        wait_cnt = $urandom_range(1, 8);
      end
      for (int p = 0; p < 4; p++) begin
        if (req[p]) begin
          m_pend[p] = 1'b1;
          m_addr[p] = (p == 1) ? a[p] : {1'b0, a[p][17:0]};
        end
      end
      if (load_en) m_pend = '0;
      if (load_en) m_dtack = 1'b1;
      else if (req[2]) m_dtack = 1'b0;
      else if (dclr) m_dtack = 1'b1;

      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_m68k();
    test_priority();
    test_overwrite();
    test_rerequest();
    test_load_en();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1);
  end

endmodule
